// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache refill path: line geometry,
// refill FSM state encoding and line-address alignment.
package cache_pkg;

  localparam int ADDR_W      = 32;
  localparam int LINE_W      = 128;
  localparam int OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Clears the byte-within-line offset so memory only ever sees whole lines.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a synchronous clear that beats increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Round-robin arbiter sharing one main-memory line port between the
// instruction cache (requester 0) and the data cache (requester 1).
module cache_refill_arbiter #(
  parameter int ADDR_W  = cache_pkg::ADDR_W,
  parameter int LINE_W  = cache_pkg::LINE_W,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              rsp_valid0,
  output logic              rsp_valid1,
  output logic              rsp_err,
  output logic [LINE_W-1:0] rsp_data,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  refill_cnt0,
  output logic [CNT_W-1:0]  refill_cnt1
);

  import cache_pkg::*;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state, state_nx;
  logic              gnt_id, gnt_nx;
  logic              last_grant, last_nx;
  logic [TW-1:0]     timer, timer_nx;
  logic              mem_req_nx, rsp_valid0_nx, rsp_valid1_nx, rsp_err_nx, busy_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [LINE_W-1:0] rsp_data_nx;
  logic              pick1;
  logic              timed_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_id     <= 1'b0;
      last_grant <= 1'b1;
      timer      <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      gnt_id     <= gnt_nx;
      last_grant <= last_nx;
      timer      <= timer_nx;
      mem_req    <= mem_req_nx;
      mem_addr   <= mem_addr_nx;
      rsp_valid0 <= rsp_valid0_nx;
      rsp_valid1 <= rsp_valid1_nx;
      rsp_err    <= rsp_err_nx;
      rsp_data   <= rsp_data_nx;
      busy       <= busy_nx;
    end
  end

  // A tie goes to whichever requester was not granted last.
  always_comb begin
    state_nx      = state;
    gnt_nx        = gnt_id;
    last_nx       = last_grant;
    timer_nx      = timer;
    mem_req_nx    = 1'b0;
    mem_addr_nx   = mem_addr;
    rsp_valid0_nx = 1'b0;
    rsp_valid1_nx = 1'b0;
    rsp_err_nx    = rsp_err;
    rsp_data_nx   = rsp_data;
    pick1         = req1 && (!req0 || !last_grant);
    timed_out     = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nx    = ISSUE;
          gnt_nx      = pick1;
          last_nx     = pick1;
          timer_nx    = '0;
          mem_req_nx  = 1'b1;
          mem_addr_nx = {(pick1 ? addr1[ADDR_W-1:OFFSET_BITS] : addr0[ADDR_W-1:OFFSET_BITS]),
                         {OFFSET_BITS{1'b0}}};
        end
      end
      ISSUE: begin
        timer_nx = timer + 1'b1;
        if (mem_ack || timed_out) begin
          state_nx      = RESP;
          rsp_err_nx    = !mem_ack;
          rsp_data_nx   = mem_ack ? mem_rdata : '0;
          rsp_valid0_nx = !gnt_id;
          rsp_valid1_nx = gnt_id;
        end else begin
          mem_req_nx = 1'b1;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // Only successful fetches count; rsp_err is still valid during RESP.
  sat_counter #(.CNT_W(CNT_W)) u_cnt0 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((state == RESP) && !rsp_err && !gnt_id),
    .clr   (clr_cnt),
    .count (refill_cnt0)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt1 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((state == RESP) && !rsp_err && gnt_id),
    .clr   (clr_cnt),
    .count (refill_cnt1)
  );

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Randomized bench for cache_refill_arbiter against a transaction-level
// model of grants, responses and saturating refill counts.
module tb_cache_refill_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int TMO    = 8;
  localparam int CW     = 2;
  localparam int CMAX   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic              rsp_valid0, rsp_valid1, rsp_err, busy, mem_req;
  logic [LINE_W-1:0] rsp_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              clr_cnt = 1'b0;
  logic [CW-1:0]     refill_cnt0, refill_cnt1;

  int total = 0;
  int bad   = 0;

  bit                pend [2];
  logic [ADDR_W-1:0] addrm [2];
  int                cnt [2];
  bit                lastg;

  cache_refill_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .clr_cnt(clr_cnt), .refill_cnt0(refill_cnt0), .refill_cnt1(refill_cnt1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Raise a new miss for one requester at the current negedge.
  task automatic applyStimulus(input int id, input logic [ADDR_W-1:0] a);
    pend[id]  = 1'b1;
    addrm[id] = a;
    if (id == 0) begin req0 = 1'b1; addr0 = a; end
    else         begin req1 = 1'b1; addr1 = a; end
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_cnt0"}, LINE_W'(refill_cnt0), LINE_W'(cnt[0]));
    checkOutput({tag, "_cnt1"}, LINE_W'(refill_cnt1), LINE_W'(cnt[1]));
  endtask

  // One complete fetch: ack after 'delay' issue cycles (>= TMO means none).
  task automatic serviceOne(input int delay, input logic [LINE_W-1:0] data, input bit clrAtResp);
    int g;
    int reqc;
    bit ok;
    logic [ADDR_W-1:0] expAddr;
    g = (pend[0] && pend[1]) ? (lastg ? 0 : 1) : (pend[0] ? 0 : 1);
    expAddr = addrm[g] & ~32'hF;
    @(negedge clk);
    checkOutput("grant_latency", LINE_W'(mem_req), 1);
    checkOutput("mem_addr", LINE_W'(mem_addr), LINE_W'(expAddr));
    checkOutput("busy_issue", LINE_W'(busy), 1);
    reqc = 0;
    while (mem_req && reqc < 40) begin
      checkOutput("mem_addr_hold", LINE_W'(mem_addr), LINE_W'(expAddr));
      mem_ack   = (reqc == delay);
      mem_rdata = mem_ack ? data : {$urandom, $urandom, $urandom, $urandom};
      reqc++;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    ok = (delay < TMO);
    checkOutput("memreq_cycles", LINE_W'(reqc), LINE_W'(ok ? delay + 1 : TMO));
    checkOutput("rsp_valid0", LINE_W'(rsp_valid0), LINE_W'(g == 0));
    checkOutput("rsp_valid1", LINE_W'(rsp_valid1), LINE_W'(g == 1));
    checkOutput("rsp_err", LINE_W'(rsp_err), LINE_W'(!ok));
    checkOutput("rsp_data", rsp_data, ok ? data : '0);
    pend[g] = 1'b0;
    if (g == 0) req0 = 1'b0; else req1 = 1'b0;
    lastg = g[0];
    if (ok) cnt[g] = (cnt[g] >= CMAX) ? CMAX : cnt[g] + 1;
    if (clrAtResp) begin
      clr_cnt = 1'b1;
      cnt[0]  = 0;
      cnt[1]  = 0;
    end
    @(negedge clk);
    clr_cnt = 1'b0;
    checkOutput("pulse_once0", LINE_W'(rsp_valid0), 0);
    checkOutput("pulse_once1", LINE_W'(rsp_valid1), 0);
    checkOutput("busy_idle", LINE_W'(busy), 0);
    checkOutput("memreq_idle", LINE_W'(mem_req), 0);
    checkCounters("post");
  endtask

  initial begin
    pend[0] = 0; pend[1] = 0; cnt[0] = 0; cnt[1] = 0; lastg = 1'b1;
    #3;
    checkOutput("rst_mem_req", LINE_W'(mem_req), 0);
    checkOutput("rst_mem_addr", LINE_W'(mem_addr), 0);
    checkOutput("rst_rsp_valid", LINE_W'({rsp_valid1, rsp_valid0}), 0);
    checkOutput("rst_rsp_err", LINE_W'(rsp_err), 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_busy", LINE_W'(busy), 0);
    checkCounters("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] tie and round-robin from reset");
    for (int r = 0; r < 2; r++) begin
      applyStimulus(0, 32'h0000_4004 + 32'(r) * 32'h100);
      applyStimulus(1, 32'h0008_800C + 32'(r) * 32'h100);
      serviceOne(1, {4{$urandom}}, 1'b0);
      serviceOne(0, {4{$urandom}}, 1'b0);
    end

    $display("[TB] single refill");
    applyStimulus(0, 32'h0000_1237);
    serviceOne(2, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 1'b0);

    $display("[TB] timeout and stray ack");
    applyStimulus(1, 32'h0000_2ABC);
    serviceOne(99, '0, 1'b0);
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("stray_memreq", LINE_W'(mem_req), 0);
    checkOutput("stray_busy", LINE_W'(busy), 0);
    @(negedge clk);
    checkOutput("stray_rsp", LINE_W'({rsp_valid1, rsp_valid0}), 0);
    checkCounters("stray");

    $display("[TB] ack on timeout cycle");
    applyStimulus(0, 32'h0000_3FF0);
    serviceOne(TMO - 1, {4{$urandom}}, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 40; i++) begin
      for (int id = 0; id < 2; id++)
        if (!pend[id] && $urandom_range(0, 1) == 1) applyStimulus(id, $urandom);
      if (!pend[0] && !pend[1]) applyStimulus(int'($urandom_range(0, 1)), $urandom);
      serviceOne(int'($urandom_range(0, 10)), {4{$urandom}}, $urandom_range(0, 7) == 0);
    end

    $display("[TB] reset mid-issue");
    applyStimulus(0, 32'h0000_5550);
    applyStimulus(1, 32'h0000_6660);
    serviceOne(0, {4{$urandom}}, 1'b0);
    applyStimulus(0, 32'h0000_7777);
    @(negedge clk);
    checkOutput("pre_rst_memreq", LINE_W'(mem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_memreq", LINE_W'(mem_req), 0);
    checkOutput("async_cnt0", LINE_W'(refill_cnt0), 0);
    checkOutput("async_cnt1", LINE_W'(refill_cnt1), 0);
    checkOutput("async_busy", LINE_W'(busy), 0);
    pend[1] = 1'b0; req1 = 1'b0;
    cnt[0] = 0; cnt[1] = 0; lastg = 1'b1;
    @(negedge clk);
    checkOutput("rst_no_rsp", LINE_W'({rsp_valid1, rsp_valid0}), 0);
    rst_n = 1'b1;
    serviceOne(3, {4{$urandom}}, 1'b0);

    $display("[TB] saturation and clear");
    for (int n = 0; n < 5; n++) begin
      applyStimulus(0, $urandom);
      serviceOne(int'($urandom_range(0, TMO - 1)), {4{$urandom}}, 1'b0);
    end
    checkOutput("sat_cnt0", LINE_W'(refill_cnt0), CMAX);
    applyStimulus(0, $urandom);
    serviceOne(0, {4{$urandom}}, 1'b1);
    checkOutput("clr_cnt0", LINE_W'(refill_cnt0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
